// File: rtl/spi_target.sv
// spi_target: mode-0 SPI target that oversamples the SPI pins in the clk_in domain
//   clk_in, rst        system clock, synchronous active-high reset
//   sclk, cs_n, mosi   asynchronous SPI pins (CPOL=0, CPHA=0, MSB first)
//   miso, miso_oe      serial data out and pad enable (high while the frame is active)
//   tx_data/valid/ready  holding-register write port (accepted on tx_valid && tx_ready)
//   rx_data, rx_valid  last complete received word and its one-cycle update pulse
//   busy               frame in progress
//   frame_err          pulse when cs_n rises mid-word
//   tx_underrun        pulse when a word load finds the holding register empty
module spi_target #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk_in,
    input  logic                  rst,
    input  logic                  sclk,
    input  logic                  cs_n,
    input  logic                  mosi,
    output logic                  miso,
    output logic                  miso_oe,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    output logic                  busy,
    output logic                  frame_err,
    output logic                  tx_underrun
);
    localparam int CW = $clog2(DATA_WIDTH);

    typedef enum logic [1:0] {WAIT_IDLE, IDLE, ACTIVE} state_t;

    state_t                state, state_nx;
    logic [1:0]            sclk_s, cs_s, mosi_s;
    logic                  sclk_h, cs_h;
    logic [DATA_WIDTH-1:0] hold_data, tx_shift, rx_next;
    logic [DATA_WIDTH-2:0] rx_shift;
    logic                  hold_full, load_pend;
    logic [CW-1:0]         bit_cnt;
    logic                  sclk_rise, sclk_fall, cs_fall, cs_high;
    logic                  load, rx_step, tx_step, abort, word_done, wr;

    assign sclk_rise = sclk_s[1] && !sclk_h;
    assign sclk_fall = !sclk_s[1] && sclk_h;
    assign cs_high   = cs_s[1];
    assign cs_fall   = !cs_s[1] && cs_h;
    assign rx_next   = {rx_shift, mosi_s[1]};
    assign word_done = rx_step && (bit_cnt == CW'(DATA_WIDTH - 1));
    assign tx_ready  = !hold_full;
    assign wr        = tx_valid && tx_ready;
    assign busy      = (state == ACTIVE);
    assign miso_oe   = busy;
    assign miso      = busy && tx_shift[DATA_WIDTH-1];

    always_ff @(posedge clk_in) begin
        if (rst) begin
            // cs_n resets to "selected" so a frame already running at reset release
            // is never mistaken for a fresh cs_n fall; WAIT_IDLE waits it out
            sclk_s <= '0;
            sclk_h <= 1'b0;
            cs_s   <= '0;
            cs_h   <= 1'b0;
            mosi_s <= '0;
            state  <= WAIT_IDLE;
        end else begin
            sclk_s <= {sclk_s[0], sclk};
            sclk_h <= sclk_s[1];
            cs_s   <= {cs_s[0], cs_n};
            cs_h   <= cs_s[1];
            mosi_s <= {mosi_s[0], mosi};
            state  <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        load     = 1'b0;
        rx_step  = 1'b0;
        tx_step  = 1'b0;
        abort    = 1'b0;
        case (state)
            WAIT_IDLE: state_nx = cs_high ? IDLE : WAIT_IDLE;
            IDLE: begin
                state_nx = cs_fall ? ACTIVE : IDLE;
                load     = cs_fall;
            end
            ACTIVE: begin
                // deselect wins over any SCLK edge seen in the same cycle
                state_nx = cs_high ? IDLE : ACTIVE;
                abort    = cs_high && (bit_cnt != '0);
                rx_step  = !cs_high && sclk_rise;
                load     = !cs_high && sclk_fall && load_pend;
                tx_step  = !cs_high && sclk_fall && !load_pend;
            end
            default: state_nx = WAIT_IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst) begin
            hold_data   <= '0;
            hold_full   <= 1'b0;
            tx_shift    <= '0;
            rx_shift    <= '0;
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            bit_cnt     <= '0;
            load_pend   <= 1'b0;
            frame_err   <= 1'b0;
            tx_underrun <= 1'b0;
        end else begin
            frame_err   <= abort;
            tx_underrun <= load && !hold_full;
            rx_valid    <= word_done;
            // a load empties the register; a write in the same cycle refills it
            hold_full   <= (hold_full && !load) || wr;
            if (wr) hold_data <= tx_data;
            if (load) tx_shift <= hold_full ? hold_data : '0;
            else if (tx_step) tx_shift <= {tx_shift[DATA_WIDTH-2:0], 1'b0};
            // the falling edge after a completed word loads instead of shifting
            load_pend   <= word_done ? 1'b1 : (load ? 1'b0 : load_pend);
            if (state == IDLE && cs_fall) bit_cnt <= '0;
            else if (rx_step) bit_cnt <= word_done ? '0 : bit_cnt + 1'b1;
            if (rx_step) rx_shift <= rx_next[DATA_WIDTH-2:0];
            if (word_done) rx_data <= rx_next;
        end
    end
endmodule

// File: tb/tb_spi_target.sv
// tb_spi_target: randomized self-checking bench for spi_target against a word-level model
module tb_spi_target;
    logic       clk_in = 1'b0, rst = 1'b1, sclk = 1'b0, cs_n = 1'b1, mosi = 1'b0, tx_valid = 1'b0;
    logic [7:0] tx_data = '0;
    logic       miso, miso_oe, tx_ready, rx_valid, busy, frame_err, tx_underrun;
    logic [7:0] rx_data;

    int         n_checks = 0, n_errors = 0;
    int         n_rxv = 0, n_fe = 0, n_ur = 0;
    int         cs_lo = 0, cs_hi = 0;
    bit         ignore_cs = 1'b1;
    logic [7:0] hold_q[$];
    logic [7:0] exp_rx[$];
    logic [7:0] model_rx = '0;
    logic [7:0] prev_rx = '0;
    logic       prev_rv = 1'b0, prev_fe = 1'b0, prev_ur = 1'b0;
    logic [15:0] miso_got = '0;

    spi_target #(.DATA_WIDTH(8)) dut (
        .clk_in(clk_in), .rst(rst), .sclk(sclk), .cs_n(cs_n), .mosi(mosi),
        .miso(miso), .miso_oe(miso_oe), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid), .busy(busy),
        .frame_err(frame_err), .tx_underrun(tx_underrun)
    );

    always #5 clk_in = ~clk_in;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model of the holding register: a word load takes the held word or zeros on underrun
    task automatic load_word(output logic [7:0] w, inout int ur);
        if (hold_q.size() > 0) w = hold_q.pop_front();
        else begin
            w = '0;
            ur++;
        end
    endtask

    task automatic write_tx(input logic [7:0] d);
        chk("tx_ready_before_write", tx_ready, hold_q.size() == 0);
        tx_data  = d;
        tx_valid = 1'b1;
        @(negedge clk_in);
        tx_valid = 1'b0;
        if (hold_q.size() == 0) hold_q.push_back(d);
    endtask

    // Controller side of one frame at clk_in/10; the last SCLK fall coincides with cs_n rise
    task automatic run_frame(input int nbits, input logic [15:0] mo, input bit mid_wr, input logic [7:0] wd);
        logic [7:0] txw, w;
        int ur0, fe0, rv0, exp_ur;
        ur0 = n_ur;
        fe0 = n_fe;
        rv0 = n_rxv;
        exp_ur = 0;
        miso_got = '0;
        cs_n = 1'b0;
        mosi = mo[nbits-1];
        load_word(txw, exp_ur);
        repeat (5) @(negedge clk_in);
        if (mid_wr) write_tx(wd);
        else @(negedge clk_in);
        repeat (2) @(negedge clk_in);
        for (int i = 0; i < nbits; i++) begin
            if (i > 0 && i % 8 == 0) load_word(txw, exp_ur);
            miso_got = {miso_got[14:0], miso};
            chk("miso_bit", miso, txw[7 - i % 8]);
            if (i % 8 == 7) begin
                w = mo[nbits-1-i +: 8];
                exp_rx.push_back(w);
                model_rx = w;
            end
            sclk = 1'b1;
            repeat (5) @(negedge clk_in);
            sclk = 1'b0;
            if (i == nbits - 1) cs_n = 1'b1;
            else mosi = mo[nbits-2-i];
            repeat (5) @(negedge clk_in);
        end
        repeat (4) @(negedge clk_in);
        chk("underrun_count", n_ur - ur0, exp_ur);
        chk("frame_err_count", n_fe - fe0, (nbits % 8) != 0);
        chk("rx_valid_count", n_rxv - rv0, nbits / 8);
        chk("busy_after_frame", busy, 1'b0);
        chk("rx_data_after_frame", rx_data, model_rx);
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, "_miso"}, miso, 1'b0);
        chk({tag, "_miso_oe"}, miso_oe, 1'b0);
        chk({tag, "_rx_data"}, rx_data, 8'h00);
        chk({tag, "_rx_valid"}, rx_valid, 1'b0);
        chk({tag, "_tx_ready"}, tx_ready, 1'b1);
        chk({tag, "_busy"}, busy, 1'b0);
        chk({tag, "_frame_err"}, frame_err, 1'b0);
        chk({tag, "_tx_underrun"}, tx_underrun, 1'b0);
    endtask

    // Per-cycle compare: pad enable, idle miso, busy vs cs_n pin history, rx words, pulse widths
    always begin
        @(posedge clk_in);
        #1;
        if (cs_n) begin
            cs_hi++;
            cs_lo = 0;
        end else begin
            cs_lo++;
            cs_hi = 0;
        end
        if (rst) begin
            ignore_cs = 1'b1;
            prev_rx = '0;
            prev_rv = 1'b0;
            prev_fe = 1'b0;
            prev_ur = 1'b0;
        end else begin
            if (cs_hi >= 4) ignore_cs = 1'b0;
            chk("miso_oe_eq_busy", miso_oe, busy);
            if (!busy) chk("miso_idle_low", miso, 1'b0);
            if (cs_hi >= 4 || ignore_cs) chk("busy_low", busy, 1'b0);
            else if (cs_lo >= 4) chk("busy_high", busy, 1'b1);
            if (rx_valid) begin
                n_rxv++;
                chk("rx_valid_single", prev_rv, 1'b0);
                if (exp_rx.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL rx_valid_unexpected: got rx_data %0h expected no rx_valid at %0t", rx_data, $time);
                end else chk("rx_data", rx_data, exp_rx.pop_front());
            end else chk("rx_data_held", rx_data, prev_rx);
            if (frame_err) begin
                n_fe++;
                chk("frame_err_single", prev_fe, 1'b0);
            end
            if (tx_underrun) begin
                n_ur++;
                chk("tx_underrun_single", prev_ur, 1'b0);
            end
            prev_rx = rx_data;
            prev_rv = rx_valid;
            prev_fe = frame_err;
            prev_ur = tx_underrun;
        end
    end

    initial begin
        int u0, f0, r0;
        logic [7:0] dummy;
        int dummy_ur;
        repeat (3) @(negedge clk_in);
        chk_reset_values("reset");
        rst = 1'b0;
        repeat (10) @(negedge clk_in);

        write_tx(8'hA5);
        run_frame(8, 16'h003C, 1'b0, 8'h00);
        chk("basic_miso_word", miso_got[7:0], 8'hA5);
        chk("basic_rx_data", rx_data, 8'h3C);
        chk("basic_tx_ready", tx_ready, 1'b1);
        repeat (3) @(negedge clk_in);

        u0 = n_ur;
        write_tx(8'h81);
        run_frame(16, 16'hF00F, 1'b1, 8'h7E);
        chk("b2b_miso_words", miso_got, 16'h817E);
        chk("b2b_rx_data", rx_data, 8'h0F);
        chk("b2b_no_underrun", n_ur - u0, 0);
        repeat (3) @(negedge clk_in);

        u0 = n_ur;
        run_frame(8, 16'h00C3, 1'b0, 8'h00);
        chk("underrun_miso_zero", miso_got[7:0], 8'h00);
        chk("underrun_once", n_ur - u0, 1);
        chk("underrun_rx_data", rx_data, 8'hC3);
        repeat (3) @(negedge clk_in);

        f0 = n_fe;
        r0 = n_rxv;
        run_frame(5, 16'h0015, 1'b0, 8'h00);
        chk("abort_frame_err", n_fe - f0, 1);
        chk("abort_no_rx_valid", n_rxv - r0, 0);
        chk("abort_rx_held", rx_data, 8'hC3);
        repeat (3) @(negedge clk_in);
        run_frame(8, 16'h0096, 1'b0, 8'h00);
        chk("after_abort_rx", rx_data, 8'h96);
        repeat (3) @(negedge clk_in);

        r0 = n_rxv;
        cs_n = 1'b0;
        mosi = 1'($urandom);
        load_word(dummy, dummy_ur);
        repeat (8) @(negedge clk_in);
        repeat (3) begin
            sclk = 1'b1;
            repeat (5) @(negedge clk_in);
            sclk = 1'b0;
            mosi = 1'($urandom);
            repeat (5) @(negedge clk_in);
        end
        sclk = 1'b1;
        rst = 1'b1;
        @(negedge clk_in);
        @(negedge clk_in);
        chk_reset_values("midreset");
        hold_q.delete();
        model_rx = '0;
        rst = 1'b0;
        repeat (5) @(negedge clk_in);
        sclk = 1'b0;
        repeat (5) @(negedge clk_in);
        repeat (5) begin
            sclk = 1'b1;
            mosi = 1'($urandom);
            repeat (5) @(negedge clk_in);
            chk("midreset_busy_low", busy, 1'b0);
            sclk = 1'b0;
            repeat (5) @(negedge clk_in);
        end
        chk("midreset_no_rx_valid", n_rxv - r0, 0);
        chk("midreset_rx_data", rx_data, 8'h00);
        cs_n = 1'b1;
        repeat (10) @(negedge clk_in);
        run_frame(8, 16'h0055, 1'b0, 8'h00);
        chk("midreset_rx_55", rx_data, 8'h55);
        repeat (3) @(negedge clk_in);

        chk("hs_ready_empty", tx_ready, 1'b1);
        tx_data = 8'h11;
        tx_valid = 1'b1;
        @(negedge clk_in);
        hold_q.push_back(8'h11);
        tx_data = 8'h22;
        repeat (4) begin
            @(negedge clk_in);
            chk("hs_ready_held_low", tx_ready, 1'b0);
        end
        run_frame(8, 16'($urandom), 1'b0, 8'h00);
        hold_q.push_back(8'h22);
        chk("hs_first_word", miso_got[7:0], 8'h11);
        chk("hs_second_accepted", tx_ready, 1'b0);
        tx_valid = 1'b0;
        repeat (3) @(negedge clk_in);
        run_frame(8, 16'($urandom), 1'b0, 8'h00);
        chk("hs_second_word", miso_got[7:0], 8'h22);
        chk("hs_ready_after", tx_ready, 1'b1);
        repeat (3) @(negedge clk_in);

        for (int k = 0; k < 20; k++) begin
            int nb;
            logic [15:0] m;
            bit mw;
            m = 16'($urandom);
            case ($urandom_range(0, 2))
                0: nb = 8;
                1: nb = 16;
                default: nb = $urandom_range(1, 15);
            endcase
            if ($urandom_range(0, 1) == 1 && hold_q.size() == 0) write_tx(8'($urandom));
            mw = (nb > 8) && ($urandom_range(0, 1) == 1);
            run_frame(nb, m, mw, 8'($urandom));
            repeat (3) @(negedge clk_in);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/spi_target.md
# spi_target

Mode-0 SPI target (slave) for the SPI interface: it is the far end of the link driven by the SPI controller's gated serial clock. It oversamples SCLK, CS_N and MOSI in the local system clock domain, deserializes MOSI into parallel words, and serializes a preloaded word onto MISO. It connects to local logic through a ready/valid transmit port and a pulsed receive port.

## Interface
- DATA_WIDTH, 8, bits per SPI word; 2..32.
- clk_in  input  1  system clock; at least 8x the SCLK frequency.
- rst  input  1  synchronous, active-high reset.
- sclk  input  1  SPI serial clock, asynchronous to clk_in; idles low (CPOL=0).
- cs_n  input  1  chip select, active low, asynchronous.
- mosi  input  1  serial data in, MSB first.
- miso  output  1  serial data out, MSB first.
- miso_oe  output  1  high while the frame is selected (for the pad tristate).
- tx_data  input  DATA_WIDTH  next word to transmit.
- tx_valid  input  1  tx_data is valid.
- tx_ready  output  1  holding register empty; a write is accepted when tx_valid && tx_ready.
- rx_data  output  DATA_WIDTH  last complete received word; held until the next word completes.
- rx_valid  output  1  one-cycle pulse when rx_data updates.
- busy  output  1  frame in progress (state ACTIVE).
- frame_err  output  1  one-cycle pulse when cs_n deasserts mid-word.
- tx_underrun  output  1  one-cycle pulse when a word load finds the holding register empty.

## Operation
- Synchronizers: sclk, cs_n and mosi each pass through 2 flops, followed by 1 history flop for edge detection.
- SCLK edges:
  - Rising edge = sync high and history low.
  - Falling edge = the converse.
- Mode 0:
  - Sample mosi on the SCLK rising edge.
  - Shift miso on the SCLK falling edge.
- States:
  - WAIT_IDLE (entered on reset): stay until synchronized cs_n = 1, then go to IDLE. This ignores any frame already in progress when reset releases.
  - IDLE: on synchronized cs_n falling, load the tx shift register from the holding register, clear the bit counter, go to ACTIVE.
  - ACTIVE: shift on SCLK edges as above. Synchronized cs_n = 1 returns to IDLE.
- Word load:
  - If the holding register is full, copy it into the shift register and mark the holding register empty.
  - If the holding register is empty, load all zeros and pulse tx_underrun.
- Receive:
  - On each rising edge, shift mosi into the LSB of rx_shift and increment the bit counter (width $clog2(DATA_WIDTH)).
  - When the counter wraps from DATA_WIDTH-1 to 0: rx_data <= {rx_shift, mosi}; pulse rx_valid.
- Back-to-back words: if cs_n stays low, the first falling edge after a word completes performs a word load instead of a shift. miso then presents the new MSB.
- miso:
  - Equals shift register MSB while ACTIVE; 0 otherwise.
  - miso_oe = busy.
- cs_n rise mid-word (counter ≠ 0):
  - Discard partial bits; no rx_valid; pulse frame_err.
  - A word loaded but not fully sent is lost; it is not restored to the holding register.
- cs_n rise on a word boundary: clean end; no error.
- TX handshake:
  - tx_ready = !hold_full.
  - If a write and a word load occur in the same cycle (impossible while full), the write fills the now-empty holding register.
  - The holding register is never overwritten while full.
- Reset values:
  - miso 0, miso_oe 0, rx_data 0, rx_valid 0, tx_ready 1, busy 0, frame_err 0, tx_underrun 0.
  - Holding register empty, bit counter 0, state WAIT_IDLE.
- Reset mid-frame: all of the above apply immediately. The remainder of the frame is ignored via WAIT_IDLE.

## Timing
- Pin-to-detect latency: 3 clk_in cycles (2 sync + 1 history). An edge is acted on in the cycle it is detected.
- miso changes 1 cycle after falling-edge detection, i.e. about 4 clk_in cycles after the SCLK pin fall.
- The first MSB is valid 4 cycles after the cs_n pin fall. The controller must wait at least 6 clk_in cycles from the cs_n fall to the first SCLK rise.
- SCLK high and low phases must each be at least 3 clk_in cycles.
- rx_valid is asserted 1 cycle after detection of the last rising edge of a word.
- busy rises 1 cycle after cs_n fall detection and falls 1 cycle after cs_n rise detection.
- frame_err and tx_underrun are single-cycle pulses.

## Test plan
- Basic word:
  - Stimulus: write tx_data=8'hA5; frame of 8 SCLK at clk_in/10 with mosi=8'h3C.
  - Required: miso bits 1,0,1,0,0,1,0,1; rx_data=8'h3C; one rx_valid pulse; tx_ready returns to 1 at frame start.
- Back-to-back:
  - Stimulus: preload 8'h81 and, after the first load, 8'h7E; 16 SCLK with cs_n held low; mosi=8'hF0 then 8'h0F.
  - Required: miso carries 81 then 7E; two rx_valid pulses with F0 then 0F; no underrun.
- Underrun:
  - Stimulus: no tx write; 8-bit frame.
  - Required: miso all 0; tx_underrun pulses once at the cs_n fall; rx still correct.
- Abort:
  - Stimulus: cs_n rises after 5 bits.
  - Required: frame_err pulse; no rx_valid; rx_data unchanged. The next full frame receives correctly starting from bit 0.
- Reset mid-frame:
  - Stimulus: assert rst after 3 bits while cs_n stays low for 5 more SCLKs.
  - Required: all outputs at reset values; no rx_valid until cs_n goes high and a new frame of 8'h55 completes with rx_data=8'h55.
- Handshake:
  - Stimulus: hold tx_valid high with 8'h11 then 8'h22.
  - Required: the second word is not accepted until the first is loaded; tx_ready stays 0 meanwhile.
